// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared types for the SPI master core.
// Holds the transfer FSM state type and the CPOL/CPHA mode constants.
package spi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam bit CPOL_IDLE_LOW  = 1'b0;
    localparam bit CPOL_IDLE_HIGH = 1'b1;
    localparam bit CPHA_LEAD      = 1'b0;
    localparam bit CPHA_TRAIL     = 1'b1;

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: half-period counter and SPI clock generator.
// Ports: clk/resetn; run (count half-periods), shift (let sclk toggle);
// tick (last cycle of a half-period), lead_edge/trail_edge (the tick
// that moves sclk away from / back to its idle level), sclk.
module spi_sclk_gen
    import spi_master_pkg::*;
#(
    parameter bit          CPOL    = CPOL_IDLE_LOW,
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic run,
    input  logic shift,
    output logic tick,
    output logic lead_edge,
    output logic trail_edge,
    output logic sclk
);

    localparam int unsigned CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick       = run && (cnt == LAST);
    // The strobe coincides with the clk edge that flips sclk, so the
    // edge type is judged from the level sclk is leaving.
    assign lead_edge  = shift && tick && (sclk == CPOL);
    assign trail_edge = shift && tick && (sclk != CPOL);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt  <= '0;
            sclk <= CPOL;
        end else begin
            if (!run || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (!shift) begin
                sclk <= CPOL;
            end else if (tick) begin
                sclk <= ~sclk;
            end
        end
    end

endmodule

// File: rtl/spi_master_core.sv
// spi_master_core: single-word SPI master with valid/ready command input.
// Ports: clk/resetn; s_cmd_valid/s_cmd_ready/s_cmd_data (word to send);
// m_rx_valid/m_rx_data (received word); sclk, cs, mosi, miso (SPI bus).
module spi_master_core
    import spi_master_pkg::*;
#(
    parameter bit          CPOL       = CPOL_IDLE_LOW,
    parameter bit          CPHA       = CPHA_LEAD,
    parameter bit          INV_CS     = 1'b0,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  s_cmd_valid,
    output logic                  s_cmd_ready,
    input  logic [DATA_WIDTH-1:0] s_cmd_data,
    output logic                  m_rx_valid,
    output logic [DATA_WIDTH-1:0] m_rx_data,
    output logic                  sclk,
    output logic                  cs,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int unsigned HPW = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [HPW-1:0] HP_LAST = HPW'(2 * DATA_WIDTH - 1);

    state_t                state;
    logic                  cs_act;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic [HPW-1:0]        hp_cnt;
    logic                  run;
    logic                  shift;
    logic                  tick;
    logic                  lead_edge;
    logic                  trail_edge;
    logic                  sample;
    logic                  update;

    assign run   = (state != ST_IDLE);
    assign shift = (state == ST_SHIFT);
    assign cs    = INV_CS ? cs_act : ~cs_act;

    spi_sclk_gen #(
        .CPOL    (CPOL),
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk        (clk),
        .resetn     (resetn),
        .run        (run),
        .shift      (shift),
        .tick       (tick),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge),
        .sclk       (sclk)
    );

    // In CPHA=0 the MSB is already on mosi from SETUP, so the last
    // trailing edge has nothing left to present.
    assign sample = (CPHA == CPHA_TRAIL) ? trail_edge : lead_edge;
    assign update = (CPHA == CPHA_TRAIL) ? lead_edge
                  : (trail_edge && (hp_cnt != HP_LAST));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            s_cmd_ready <= 1'b0;
            cs_act      <= 1'b0;
            mosi        <= 1'b0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            hp_cnt      <= '0;
            m_rx_valid  <= 1'b0;
            m_rx_data   <= '0;
        end else begin
            m_rx_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (s_cmd_valid && s_cmd_ready) begin
                        s_cmd_ready <= 1'b0;
                        cs_act      <= 1'b1;
                        hp_cnt      <= '0;
                        state       <= ST_SETUP;
                        if (CPHA == CPHA_LEAD) begin
                            mosi  <= s_cmd_data[DATA_WIDTH-1];
                            tx_sr <= s_cmd_data << 1;
                        end else begin
                            mosi  <= 1'b0;
                            tx_sr <= s_cmd_data;
                        end
                    end else begin
                        s_cmd_ready <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (sample) begin
                        rx_sr <= {rx_sr[DATA_WIDTH-2:0], miso};
                    end
                    if (update) begin
                        mosi  <= tx_sr[DATA_WIDTH-1];
                        tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
                    end
                    if (tick) begin
                        hp_cnt <= hp_cnt + 1'b1;
                        if (hp_cnt == HP_LAST) begin
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        cs_act     <= 1'b0;
                        mosi       <= 1'b0;
                        m_rx_valid <= 1'b1;
                        m_rx_data  <= rx_sr;
                        state      <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // Raise ready together with the return to IDLE so a
                    // waiting command is taken on the first IDLE cycle.
                    if (tick) begin
                        s_cmd_ready <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_core.sv
// tb_spi_master_core: self-checking bench for spi_master_core.
// Four instances cover modes 0/3/2, CLK_DIV 1..3, 16-bit loopback, INV_CS.
module tb_spi_master_core;

    localparam int NI = 4;
    localparam bit          CFG_CPOL [NI] = '{1'b0, 1'b1, 1'b0, 1'b1};
    localparam bit          CFG_CPHA [NI] = '{1'b0, 1'b1, 1'b0, 1'b0};
    localparam bit          CFG_INV  [NI] = '{1'b0, 1'b0, 1'b0, 1'b1};
    localparam bit          CFG_LOOP [NI] = '{1'b0, 1'b0, 1'b1, 1'b0};
    localparam int unsigned CFG_DW   [NI] = '{8, 8, 16, 8};
    localparam int unsigned CFG_CD   [NI] = '{2, 2, 1, 3};

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]       valid_v = '0;
    logic [NI-1:0]       ready_v;
    logic [NI-1:0]       rxv_v;
    logic [NI-1:0]       sclk_v;
    logic [NI-1:0]       cs_v;
    logic [NI-1:0]       mosi_v;
    logic [NI-1:0]       miso_v = '0;
    logic [NI-1:0][31:0] rxd_v;
    logic [31:0]         cmd_v [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned DW_G = CFG_DW[g];
        logic [DW_G-1:0] rxd;
        logic            miso_in;
        assign miso_in  = CFG_LOOP[g] ? mosi_v[g] : miso_v[g];
        assign rxd_v[g] = 32'(rxd);
        spi_master_core #(
            .CPOL       (CFG_CPOL[g]),
            .CPHA       (CFG_CPHA[g]),
            .INV_CS     (CFG_INV[g]),
            .DATA_WIDTH (DW_G),
            .CLK_DIV    (CFG_CD[g])
        ) u_dut (
            .clk         (clk),
            .resetn      (resetn),
            .s_cmd_valid (valid_v[g]),
            .s_cmd_ready (ready_v[g]),
            .s_cmd_data  (cmd_v[g][DW_G-1:0]),
            .m_rx_valid  (rxv_v[g]),
            .m_rx_data   (rxd),
            .sclk        (sclk_v[g]),
            .cs          (cs_v[g]),
            .mosi        (mosi_v[g]),
            .miso        (miso_in)
        );
    end

    // Slave BFM and bus monitor state, one slot per instance.
    logic [31:0] slv_word [NI];
    logic [31:0] mosi_cap [NI];
    logic [31:0] rx_word  [NI];
    logic [31:0] mosi_q   [$];
    int cs_run [NI], gap_run [NI], cs_len [NI], gap_len [NI];
    int smp_cnt [NI], sent [NI], rx_cnt [NI], bad [NI];
    bit prev_act [NI], prev_sclk [NI];
    bit act, lead;

    initial begin
        for (int i = 0; i < NI; i++) begin
            slv_word[i] = '0; mosi_cap[i] = '0; rx_word[i] = '0;
            cmd_v[i] = '0;
            cs_run[i] = 0; gap_run[i] = 0; cs_len[i] = 0; gap_len[i] = 0;
            smp_cnt[i] = 0; sent[i] = 0; rx_cnt[i] = 0; bad[i] = 0;
            prev_act[i] = 1'b0; prev_sclk[i] = CFG_CPOL[i];
        end
    end

    // Slave: samples mosi on its sample edge, presents the next miso bit
    // on the opposite edge (CPHA=0 also presents the MSB at cs assert).
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            act = (cs_v[i] == CFG_INV[i]);
            if (act) begin
                if (!prev_act[i]) begin
                    gap_len[i] = gap_run[i];
                    cs_run[i] = 0; smp_cnt[i] = 0; sent[i] = 0;
                    mosi_cap[i] = '0;
                    miso_v[i] = 1'b0;
                    if (!CFG_CPHA[i]) begin
                        miso_v[i] = slv_word[i][CFG_DW[i] - 1];
                        sent[i] = 1;
                    end
                end else if (sclk_v[i] != prev_sclk[i]) begin
                    lead = (sclk_v[i] != CFG_CPOL[i]);
                    if (lead == !CFG_CPHA[i]) begin
                        mosi_cap[i] = {mosi_cap[i][30:0], mosi_v[i]};
                        smp_cnt[i]++;
                    end else if (sent[i] < int'(CFG_DW[i])) begin
                        miso_v[i] = slv_word[i][int'(CFG_DW[i]) - 1 - sent[i]];
                        sent[i]++;
                    end
                end
                cs_run[i]++;
                if (rxv_v[i]) bad[i]++;
            end else begin
                if (prev_act[i]) begin
                    cs_len[i] = cs_run[i];
                    gap_run[i] = 0;
                    if (i == 0) mosi_q.push_back(mosi_cap[0]);
                end else if (resetn && sclk_v[i] != prev_sclk[i]) begin
                    bad[i]++;
                end
                gap_run[i]++;
                if (resetn && mosi_v[i]) bad[i]++;
            end
            if (rxv_v[i]) begin
                rx_cnt[i]++;
                rx_word[i] = rxd_v[i];
            end
            prev_act[i] = act;
            prev_sclk[i] = sclk_v[i];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] mask(input int i);
        return (32'd1 << CFG_DW[i]) - 32'd1;
    endfunction

    // Reference: the slave word comes back, or the command on loopback.
    function automatic logic [31:0] model_rx(input int i,
            input logic [31:0] cmd, input logic [31:0] slv);
        return CFG_LOOP[i] ? cmd : slv;
    endfunction

    function automatic int model_cs_len(input int i);
        return (2 * int'(CFG_DW[i]) + 2) * int'(CFG_CD[i]);
    endfunction

    task automatic wait_ready(input int i, input string name);
        int t = 0;
        while (!ready_v[i] && t < 300) begin tick(); t++; end
        if (!ready_v[i]) begin
            check({name, "_ready_timeout"}, 32'(ready_v[i]), 32'd1);
            valid_v[i] = 1'b0;
        end
    endtask

    task automatic send(input int i, input logic [31:0] cmd,
                        input logic [31:0] slv, input string name);
        slv_word[i] = slv;
        cmd_v[i] = cmd;
        valid_v[i] = 1'b1;
        wait_ready(i, name);
        tick();
        valid_v[i] = 1'b0;
    endtask

    task automatic wait_rx(input int i, input int target, input string name);
        int t = 0;
        while (rx_cnt[i] < target && t < 1000) begin tick(); t++; end
        if (rx_cnt[i] < target) begin
            check({name, "_rx_timeout"}, 32'(rx_cnt[i]), 32'(target));
        end
    endtask

    task automatic run_xfer(input int i, input logic [31:0] cmd,
            input logic [31:0] slv, input logic [31:0] exp_rx,
            input int exp_len, input int exp_smp, input string name);
        int base = rx_cnt[i];
        send(i, cmd, slv, name);
        wait_rx(i, base + 1, name);
        tick();
        check({name, "_rx"}, rx_word[i], exp_rx);
        check({name, "_rxhold"}, rxd_v[i], exp_rx);
        check({name, "_mosi"}, mosi_cap[i], cmd);
        check({name, "_cslen"}, 32'(cs_len[i]), 32'(exp_len));
        check({name, "_samples"}, 32'(smp_cnt[i]), 32'(exp_smp));
        check({name, "_pulses"}, 32'(rx_cnt[i] - base), 32'd1);
        check({name, "_sclk_idle"}, 32'(sclk_v[i]), 32'(CFG_CPOL[i]));
        check({name, "_cs_idle"}, 32'(cs_v[i]), 32'(!CFG_INV[i]));
    endtask

    typedef struct {
        int          inst;
        logic [31:0] cmd;
        logic [31:0] slv;
        logic [31:0] exp_rx;
        int          exp_len;
        int          exp_smp;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int base;
        int t;
        logic [31:0] cmd, slv;
        int i;

        vecs[0] = '{0, 32'hA5,   32'h3C, 32'h3C,   36, 8};
        vecs[1] = '{1, 32'h81,   32'hFF, 32'hFF,   36, 8};
        vecs[2] = '{2, 32'hBEEF, 32'h00, 32'hBEEF, 34, 16};
        vecs[3] = '{3, 32'hC3,   32'h5A, 32'h5A,   54, 8};
        vecs[4] = '{0, 32'hFF,   32'h00, 32'h00,   36, 8};
        vecs[5] = '{1, 32'h00,   32'hA5, 32'hA5,   36, 8};
        vecs[6] = '{3, 32'h01,   32'h80, 32'h80,   54, 8};

        repeat (3) tick();
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_sclk%0d", k), 32'(sclk_v[k]), 32'(CFG_CPOL[k]));
            check($sformatf("rst_cs%0d", k), 32'(cs_v[k]), 32'(!CFG_INV[k]));
            check($sformatf("rst_mosi%0d", k), 32'(mosi_v[k]), 32'd0);
            check($sformatf("rst_ready%0d", k), 32'(ready_v[k]), 32'd0);
            check($sformatf("rst_rxv%0d", k), 32'(rxv_v[k]), 32'd0);
            check($sformatf("rst_rxd%0d", k), rxd_v[k], 32'd0);
        end
        resetn = 1'b1;
        #1;
        check("ready_before_edge", 32'(ready_v), 32'h0);
        tick();
        check("ready_first_edge", 32'(ready_v), 32'hF);

        for (int k = 0; k < 7; k++) begin
            run_xfer(vecs[k].inst, vecs[k].cmd, vecs[k].slv, vecs[k].exp_rx,
                     vecs[k].exp_len, vecs[k].exp_smp, $sformatf("vec%0d", k));
        end

        // Back-to-back with valid held high.
        tick();
        mosi_q.delete();
        base = rx_cnt[0];
        slv_word[0] = 32'h96;
        cmd_v[0] = 32'h11;
        valid_v[0] = 1'b1;
        wait_ready(0, "b2b_first");
        tick();
        cmd_v[0] = 32'h22;
        wait_ready(0, "b2b_second");
        tick();
        valid_v[0] = 1'b0;
        wait_rx(0, base + 2, "b2b");
        repeat (20) tick();
        check("b2b_pulses", 32'(rx_cnt[0] - base), 32'd2);
        check("b2b_gap", 32'(gap_len[0]), 32'd3);
        check("b2b_qsize", 32'(mosi_q.size()), 32'd2);
        if (mosi_q.size() == 2) begin
            check("b2b_mosi1", mosi_q[0], 32'h11);
            check("b2b_mosi2", mosi_q[1], 32'h22);
        end
        check("b2b_rx", rx_word[0], 32'h96);

        // Reset in the middle of SHIFT.
        base = rx_cnt[0];
        send(0, 32'h96, 32'h69, "abort");
        t = 0;
        while (smp_cnt[0] < 4 && t < 200) begin tick(); t++; end
        check("abort_reach4", 32'(smp_cnt[0] >= 4), 32'd1);
        check("abort_cs_before", 32'(cs_v[0]), 32'd0);
        resetn = 1'b0;
        #1;
        check("abort_cs", 32'(cs_v[0]), 32'd1);
        check("abort_sclk", 32'(sclk_v[0]), 32'd0);
        check("abort_mosi", 32'(mosi_v[0]), 32'd0);
        check("abort_rxv", 32'(rxv_v[0]), 32'd0);
        check("abort_rxd", rxd_v[0], 32'd0);
        repeat (3) tick();
        resetn = 1'b1;
        repeat (3) tick();
        check("abort_nopulse", 32'(rx_cnt[0] - base), 32'd0);
        run_xfer(0, 32'h5A, 32'hC5, 32'hC5, 36, 8, "after_abort");

        // Random transfers against the reference model.
        for (int k = 0; k < 24; k++) begin
            i = int'($urandom_range(0, NI - 1));
            cmd = $urandom & mask(i);
            slv = $urandom & mask(i);
            run_xfer(i, cmd, slv, model_rx(i, cmd, slv), model_cs_len(i),
                     int'(CFG_DW[i]), $sformatf("rnd%0d_i%0d", k, i));
        end

        for (int k = 0; k < NI; k++) begin
            check($sformatf("bus_rules%0d", k), 32'(bad[k]), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
